stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/chad_stack_pkg.sv | 31 +++
 rtl/stack_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_stack_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chad_stack_pkg.sv
// -----------------------------------------------------------------------------
// chad_stack_pkg
// Shared definitions for the stack controller: command op codes, controller
// state encoding and the stk_delta strobe encodings driven towards the stack.
// -----------------------------------------------------------------------------
package chad_stack_pkg;

  // Command op codes carried on cmd_op; codes 6 and 7 fall through as NOP.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_DROPN   = 3'd4,
    OP_CLEAR   = 3'd5
  } cmd_op_e;

  // Controller states: IDLE waits, ISSUE follows a single-cycle op,
  // MULTI streams the pops of a DROPN or CLEAR.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_MULTI = 2'd2
  } state_e;

  // stk_delta encodings: bit0 = move, bit1 = direction (1 pop, 0 push).
  localparam logic [1:0] DELTA_IDLE = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;

endpackage

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Command front-end for a head+tail hardware stack. Accepts PUSH / POP /
// REPLACE / DROPN / CLEAR commands over a valid/ready handshake and turns them
// into registered strobes (stk_hold, stk_we, stk_delta, stk_wd) for the stack
// datapath, one cycle after acceptance. DROPN and CLEAR expand into a burst of
// POP cycles while cmd_ready is held low.
//
// Optional feature: define STACK_CTRL_GUARD_EN to suppress overflowing and
// underflowing operations and raise the sticky err_ovf / err_unf flags.
// Without it every op is issued unchecked and the error flags stay 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready command handshake
//   cmd_op          op code (see chad_stack_pkg)
//   cmd_n           DROPN count
//   cmd_data        PUSH / REPLACE data
//   stk_hold        1 in cycles carrying no stack operation
//   stk_we          stack write strobe
//   stk_delta       stack pointer move (bit0 move, bit1 pop direction)
//   stk_wd          stack write data
//   depth           live entry count, updated as each strobe cycle ends
//   empty/full/busy status flags
//   err_ovf/err_unf sticky error flags, err_clr clears both
// -----------------------------------------------------------------------------
module stack_ctrl
  import chad_stack_pkg::*;
#(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 16,
  localparam int CAP   = DEPTH + 1,
  localparam int CW    = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CW-1:0]    cmd_n,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             stk_hold,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
);

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             we_q, we_d;
  logic [1:0]       delta_q, delta_d;
  logic             hold_q, hold_d;
  logic [WIDTH-1:0] wd_q, wd_d;

  logic             accept;
  logic             cnt_full;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    cnt_dec;
  logic [CW-1:0]    pop_n;
  logic             unf_clip;
  logic             ovf_evt;
  logic             unf_evt;

  // cnt_q is the count as of the last accepted operation, so back-to-back
  // commands see the effect of the one still in its strobe cycle. The visible
  // depth is a one-edge-delayed copy, so it changes as each strobe cycle ends.
  assign cnt_full = (cnt_q == CAP_C);
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + 1'b1;
  assign cnt_dec  = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;

  // rdy_q stays low through reset and rises on the first edge after it.
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_ready = rdy_q & (state_q != ST_MULTI);

  assign stk_hold  = hold_q;
  assign stk_we    = we_q;
  assign stk_delta = delta_q;
  assign stk_wd    = wd_q;
  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == CAP_C);
  assign busy      = (state_q == ST_MULTI);

  // Number of pops a DROPN or CLEAR expands into. CLEAR pops everything; a
  // guarded DROPN asking for more than is present is clipped and flagged.
  always_comb begin
    pop_n    = '0;
    unf_clip = 1'b0;
    if (cmd_op == OP_CLEAR) begin
      pop_n = cnt_q;
    end else if (cmd_op == OP_DROPN) begin
      pop_n = cmd_n;
      if (GUARD_EN && (cmd_n > cnt_q)) begin
        pop_n    = cnt_q;
        unf_clip = 1'b1;
      end
    end
  end

  // Next-state and next-strobe logic. Strobes default to an idle cycle; an
  // accepted command loads the strobe it will present during the next cycle.
  // In MULTI the first pop was already issued on acceptance, so rem_q holds
  // the pops still to go and the last MULTI cycle returns to IDLE.
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    cnt_d   = cnt_q;
    depth_d = cnt_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    delta_d = DELTA_IDLE;
    hold_d  = 1'b1;
    wd_d    = '0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    case (state_q)
      ST_MULTI: begin
        if (rem_q != '0) begin
          delta_d = DELTA_POP;
          hold_d  = 1'b0;
          rem_d   = rem_q - 1'b1;
          cnt_d   = cnt_dec;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          case (cmd_op)
            OP_PUSH: begin
              if (GUARD_EN && cnt_full) begin
                ovf_evt = 1'b1;
              end else begin
                we_d    = 1'b1;
                delta_d = DELTA_PUSH;
                hold_d  = 1'b0;
                wd_d    = cmd_data;
                cnt_d   = cnt_inc;
                state_d = ST_ISSUE;
              end
            end

            OP_POP: begin
              if (GUARD_EN && (cnt_q == '0)) begin
                unf_evt = 1'b1;
              end else begin
                delta_d = DELTA_POP;
                hold_d  = 1'b0;
                cnt_d   = cnt_dec;
                state_d = ST_ISSUE;
              end
            end

            OP_REPLACE: begin
              if (GUARD_EN && (cnt_q == '0)) begin
                unf_evt = 1'b1;
              end else begin
                we_d    = 1'b1;
                delta_d = DELTA_IDLE;
                hold_d  = 1'b0;
                wd_d    = cmd_data;
                state_d = ST_ISSUE;
              end
            end

            OP_DROPN, OP_CLEAR: begin
              unf_evt = unf_clip;
              if (pop_n != '0) begin
                delta_d = DELTA_POP;
                hold_d  = 1'b0;
                cnt_d   = cnt_dec;
                rem_d   = pop_n - 1'b1;
                state_d = ST_MULTI;
              end
            end

            default: begin
            end
          endcase
        end
      end
    endcase
  end

  // Main state and strobe registers. Reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      depth_q <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      delta_q <= DELTA_IDLE;
      hold_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      delta_q <= delta_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
    end
  end

`ifdef STACK_CTRL_GUARD_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  // Sticky error flags; a new event on the same edge as err_clr wins.
  always_comb begin
    err_ovf_d = (err_ovf_q & ~err_clr) | ovf_evt;
    err_unf_d = (err_unf_q & ~err_clr) | unf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, ovf_evt, unf_evt};
  assign err_ovf    = 1'b0;
  assign err_unf    = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl. Each scenario task drives commands,
// pushes the strobes it expects onto a scoreboard queue and pops them as the
// DUT presents its registered strobes. Builds with or without
// STACK_CTRL_GUARD_EN; expectations follow the same macro.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

  localparam int WIDTH = 18;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 1;
  localparam int CW    = $clog2(CAP + 1);

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_DROPN   = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op    = '0;
  logic [CW-1:0]    cmd_n     = '0;
  logic [WIDTH-1:0] cmd_data  = '0;
  logic             stk_hold;
  logic             stk_we;
  logic [1:0]       stk_delta;
  logic [WIDTH-1:0] stk_wd;
  logic [CW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             busy;
  logic             err_ovf;
  logic             err_unf;
  logic             err_clr   = 1'b0;

  int total = 0;
  int bad   = 0;

  // Strobe bundle {hold, we, delta, wd} as seen by the stack.
  typedef logic [WIDTH+3:0] strobe_t;
  strobe_t exp_q[$];
  strobe_t obs;
  assign obs = {stk_hold, stk_we, stk_delta, stk_wd};

  function automatic strobe_t mk(input logic hold, input logic we,
                                 input logic [1:0] delta,
                                 input logic [WIDTH-1:0] wd);
    return {hold, we, delta, wd};
  endfunction

  localparam strobe_t S_IDLE = {1'b1, 1'b0, 2'b00, {WIDTH{1'b0}}};
  localparam strobe_t S_POP  = {1'b0, 1'b0, 2'b11, {WIDTH{1'b0}}};

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_n     (cmd_n),
    .cmd_data  (cmd_data),
    .stk_hold  (stk_hold),
    .stk_we    (stk_we),
    .stk_delta (stk_delta),
    .stk_wd    (stk_wd),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .busy      (busy),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command; returns in the cycle its strobe is presented.
  task automatic send(input logic [2:0] op, input logic [CW-1:0] n,
                      input logic [WIDTH-1:0] d);
    int waited = 0;
    cmd_op   = op;
    cmd_n    = n;
    cmd_data = d;
    while (!cmd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Back-to-back pushes, then two cycles for depth to catch up.
  task automatic fill(input int k);
    for (int i = 0; i < k; i++) send(OP_PUSH, '0, WIDTH'(i + 1));
    step();
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if ({cmd_ready, busy, err_ovf, err_unf} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL rst_flags got %b want 0000", {cmd_ready, busy, err_ovf, err_unf});
    end
    total++;
    if (depth !== '0 || obs !== S_IDLE) begin
      bad++;
      $display("[TB] FAIL rst_state depth=%0d strobe=%h want 0 %h", depth, obs, S_IDLE);
    end
    rst = 1'b0;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_ready_early got %b want 0", cmd_ready);
    end
    step();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_ready_rise got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_push_b2b();
    strobe_t e;
    cmd_op    = OP_PUSH;
    cmd_data  = 18'h3FFFF;
    cmd_valid = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 18'h3FFFF));
    step();
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL push0_strobe got %h want %h", obs, e);
    end
    cmd_data = 18'h00001;
    exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 18'h00001));
    step();
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL push1_strobe got %h want %h", obs, e);
    end
    total++;
    if (depth !== CW'(1)) begin
      bad++;
      $display("[TB] FAIL push_depth_lag got %0d want 1", depth);
    end
    step();
    total++;
    if (obs !== S_IDLE || depth !== CW'(2)) begin
      bad++;
      $display("[TB] FAIL push_final strobe=%h depth=%0d want %h 2", obs, depth, S_IDLE);
    end
  endtask

  task automatic test_dropn();
    strobe_t e;
    do_reset();
    fill(5);
    total++;
    if (depth !== CW'(5)) begin
      bad++;
      $display("[TB] FAIL dropn_pre_depth got %0d want 5", depth);
    end
    send(OP_DROPN, CW'(3), '0);
    for (int i = 0; i < 3; i++) exp_q.push_back(S_POP);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL dropn_pop strobe=%h busy=%b ready=%b want %h 1 0", obs, busy, cmd_ready, e);
      end
      step();
    end
    total++;
    if (obs !== S_IDLE || busy !== 1'b0 || depth !== CW'(2)) begin
      bad++;
      $display("[TB] FAIL dropn_end strobe=%h busy=%b depth=%0d want %h 0 2", obs, busy, depth, S_IDLE);
    end
  endtask

  task automatic test_replace();
    strobe_t e;
    send(OP_PUSH, '0, 18'h00007);
    step();
    step();
    send(OP_REPLACE, '0, 18'h12345);
    exp_q.push_back(mk(1'b0, 1'b1, 2'b00, 18'h12345));
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL replace_strobe got %h want %h", obs, e);
    end
    step();
    step();
    total++;
    if (obs !== S_IDLE || depth !== CW'(3)) begin
      bad++;
      $display("[TB] FAIL replace_end strobe=%h depth=%0d want %h 3", obs, depth, S_IDLE);
    end
  endtask

  task automatic test_overflow();
    strobe_t e;
    do_reset();
    fill(CAP);
    total++;
    if (depth !== CW'(CAP) || full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_pre depth=%0d full=%b want %0d 1", depth, full, CAP);
    end
    send(OP_PUSH, '0, 18'h2AAAA);
    exp_q.push_back(GUARD ? S_IDLE : mk(1'b0, 1'b1, 2'b01, 18'h2AAAA));
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL ovf_strobe got %h want %h", obs, e);
    end
    step();
    total++;
    if (depth !== CW'(CAP) || err_ovf !== GUARD) begin
      bad++;
      $display("[TB] FAIL ovf_flag depth=%0d err_ovf=%b want %0d %b", depth, err_ovf, CAP, GUARD);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++;
    if (err_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_clear got %b want 0", err_ovf);
    end
  endtask

  task automatic test_underflow();
    strobe_t e;
    do_reset();
    fill(2);
    send(OP_DROPN, CW'(5), '0);
    for (int i = 0; i < (GUARD ? 2 : 5); i++) exp_q.push_back(S_POP);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL unf_pop got %h want %h", obs, e);
      end
      step();
    end
    total++;
    if (obs !== S_IDLE || depth !== '0 || empty !== 1'b1 || err_unf !== GUARD) begin
      bad++;
      $display("[TB] FAIL unf_end strobe=%h depth=%0d empty=%b err_unf=%b want %h 0 1 %b",
               obs, depth, empty, err_unf, S_IDLE, GUARD);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    send(OP_POP, '0, '0);
    exp_q.push_back(GUARD ? S_IDLE : S_POP);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL unf_pop_empty got %h want %h", obs, e);
    end
    step();
    total++;
    if (depth !== '0 || err_unf !== GUARD) begin
      bad++;
      $display("[TB] FAIL unf_pop_flag depth=%0d err_unf=%b want 0 %b", depth, err_unf, GUARD);
    end
  endtask

  task automatic test_clear_reset();
    strobe_t e;
    do_reset();
    fill(9);
    send(OP_CLEAR, '0, '0);
    exp_q.push_back(S_POP);
    exp_q.push_back(S_POP);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL clear_pop strobe=%h busy=%b want %h 1", obs, busy, e);
      end
      if (exp_q.size() > 0) step();
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || depth !== '0 || obs !== S_IDLE || cmd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_rst busy=%b depth=%0d strobe=%h ready=%b want 0 0 %h 0",
               busy, depth, obs, cmd_ready, S_IDLE);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs !== S_IDLE || busy !== 1'b0 || depth !== '0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL clear_after strobe=%h busy=%b depth=%0d ready=%b want %h 0 0 1",
                 obs, busy, depth, cmd_ready, S_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_b2b();
    test_dropn();
    test_replace();
    test_overflow();
    test_underflow();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
